// File: rtl/aftab_arb_pkg.sv
// Shared definitions for the AFTAB core/debug memory arbiter: state encoding,
// requester indices and counter width helper.
package aftab_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GNT_CORE = 2'b01,
        GNT_DBG  = 2'b10,
        ERR      = 2'b11
    } arbState_t;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

    // Bits needed to hold the values 0..maxVal.
    function automatic int cntWidth(input int maxVal);
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/aftab_arb_timeout.sv
// Loadable up-counter that saturates at LIMIT; expire is high while the count
// sits at LIMIT. Used for both the ready timeout and the debug starvation count.
module aftab_arb_timeout
    import aftab_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 254
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic             expire
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = (count == LIMIT_V);

endmodule

// File: rtl/aftab_mem_arbiter.sv
// Shares the byte-wide memory port between the AFTAB core and the debug memory
// path, holding the grant across locked multi-byte transactions.
//
//   state    | meaning
//   IDLE     | no owner; arbitrate active requesters
//   GNT_CORE | core owns the memory port
//   GNT_DBG  | debug path owns the memory port
//   ERR      | owner timed out; wait for it to release, grant nobody
module aftab_mem_arbiter
    import aftab_arb_pkg::*;
#(
    parameter int size           = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DBG_MAX_CONSEC = 4
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            core_mem_read,
    input  logic            core_mem_write,
    input  logic            core_mem_lock,
    input  logic [size-1:0] core_mem_addr,
    input  logic [7:0]      core_mem_data_out,
    output logic            core_mem_ready,
    output logic            core_mem_err,
    input  logic            dbg_mem_read,
    input  logic            dbg_mem_write,
    input  logic            dbg_mem_lock,
    input  logic [size-1:0] dbg_mem_addr,
    input  logic [7:0]      dbg_mem_data_out,
    output logic            dbg_mem_ready,
    output logic            dbg_mem_err,
    input  logic [7:0]      mem_data_in,
    input  logic            mem_ready,
    output logic            mem_read,
    output logic            mem_write,
    output logic [size-1:0] mem_addr,
    output logic [7:0]      mem_data_out,
    output logic            grant_core,
    output logic            grant_dbg
);

    localparam int TMO_W = cntWidth(TIMEOUT_CYCLES);
    localparam int STV_W = cntWidth(DBG_MAX_CONSEC);

    arbState_t state;
    logic      grantCore, grantDbg, coreErr, dbgErr, errOwner;

    logic coreActive, coreHolding, dbgActive, dbgHolding;
    logic inCore, inDbg, inIdle, granted, ownerActive;
    logic dbgWins, coreWins, starveFull, starveInc, starveClr;
    logic tmoClr, tmoInc, tmoExpire, timeoutHit;
    logic unusedDataIn;

    // Read data is wired straight from memory to both requesters outside this block.
    assign unusedDataIn = ^mem_data_in;

    assign coreActive  = core_mem_read | core_mem_write;
    assign coreHolding = coreActive | core_mem_lock;
    assign dbgActive   = dbg_mem_read | dbg_mem_write;
    assign dbgHolding  = dbgActive | dbg_mem_lock;

    assign inCore      = (state == GNT_CORE);
    assign inDbg       = (state == GNT_DBG);
    assign inIdle      = (state == IDLE);
    assign granted     = inCore | inDbg;
    assign ownerActive = (inCore & coreActive) | (inDbg & dbgActive);

    assign dbgWins   = dbgActive & (~coreActive | ~starveFull);
    assign coreWins  = coreActive & ~dbgWins;
    assign starveInc = inIdle & dbgWins & coreActive;
    assign starveClr = inIdle & (~coreActive | coreWins);

    // Counter saturates one below the limit: the next unready cycle is the fatal one.
    assign tmoClr     = ~granted | mem_ready;
    assign tmoInc     = ownerActive & ~mem_ready;
    assign timeoutHit = tmoInc & tmoExpire;

    aftab_arb_timeout #(.WIDTH(TMO_W), .LIMIT(TIMEOUT_CYCLES - 1)) uTimeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmoClr),
        .inc     (tmoInc),
        .load    (1'b0),
        .loadVal ('0),
        .expire  (tmoExpire)
    );

    aftab_arb_timeout #(.WIDTH(STV_W), .LIMIT(DBG_MAX_CONSEC)) uStarve (
        .clk     (clk),
        .rst     (rst),
        .clr     (starveClr),
        .inc     (starveInc),
        .load    (1'b0),
        .loadVal ('0),
        .expire  (starveFull)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grantCore <= 1'b0;
            grantDbg  <= 1'b0;
            coreErr   <= 1'b0;
            dbgErr    <= 1'b0;
            errOwner  <= 1'b0;
        end else begin
            coreErr <= 1'b0;
            dbgErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbgWins) begin
                        state    <= GNT_DBG;
                        grantDbg <= 1'b1;
                    end else if (coreWins) begin
                        state     <= GNT_CORE;
                        grantCore <= 1'b1;
                    end
                end
                GNT_CORE: begin
                    if (timeoutHit) begin
                        state     <= ERR;
                        grantCore <= 1'b0;
                        coreErr   <= 1'b1;
                        errOwner  <= 1'(REQ_CORE);
                    end else if (!coreHolding) begin
                        state     <= IDLE;
                        grantCore <= 1'b0;
                    end
                end
                GNT_DBG: begin
                    if (timeoutHit) begin
                        state    <= ERR;
                        grantDbg <= 1'b0;
                        dbgErr   <= 1'b1;
                        errOwner <= 1'(REQ_DBG);
                    end else if (!dbgHolding) begin
                        state    <= IDLE;
                        grantDbg <= 1'b0;
                    end
                end
                ERR: begin
                    if (errOwner == 1'(REQ_CORE) ? !coreHolding : !dbgHolding) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write wins over a simultaneous read from the same owner.
    assign mem_write    = (inCore & core_mem_write) | (inDbg & dbg_mem_write);
    assign mem_read     = (inCore & core_mem_read & ~core_mem_write)
                        | (inDbg & dbg_mem_read & ~dbg_mem_write);
    assign mem_addr     = inCore ? core_mem_addr : (inDbg ? dbg_mem_addr : '0);
    assign mem_data_out = inCore ? core_mem_data_out : (inDbg ? dbg_mem_data_out : 8'h00);

    assign core_mem_ready = inCore & mem_ready;
    assign dbg_mem_ready  = inDbg & mem_ready;
    assign core_mem_err   = coreErr;
    assign dbg_mem_err    = dbgErr;
    assign grant_core     = grantCore;
    assign grant_dbg      = grantDbg;

endmodule
